// File: rtl/kyber_intt_core.sv
// Kyber inverse NTT core: loads one 256-coefficient polynomial (8 lanes/word),
// runs the 7 Gentleman-Sande layers in place (one butterfly per cycle through
// a 3-stage pipeline), scales by 128^-1 mod q, then streams the result out.
module kyber_intt_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  output logic         ready_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  output logic         done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_SCALE   = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [11:0] SCALE_F = 12'd3303;

  // 17^brv7(k) mod 3329, evaluated at elaboration to fill the zeta ROM.
  function automatic logic [11:0] zeta_of(input int k);
    int e;
    int r;
    e = 0;
    for (int b = 0; b < 7; b++) begin
      if (((k >> b) & 1) != 0) e = e | (1 << (6 - b));
    end
    r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % 3329;
    return 12'(r);
  endfunction

  // Barrett reduction of a 24-bit product. floor(2^24/q) = 5039 makes the
  // quotient estimate at most one short, so one conditional subtract suffices.
  function automatic logic [11:0] mod_q(input logic [23:0] x);
    logic [36:0] est;
    logic [12:0] qt;
    logic [23:0] rem;
    est = 37'(x) * 37'd5039;
    qt  = 13'(est >> 24);
    rem = x - 24'(qt) * 24'd3329;
    if (rem >= 24'd3329) rem = rem - 24'd3329;
    return 12'(rem);
  endfunction

  logic [2:0]   state_q, state_d;
  logic [4:0]   word_cnt_q, word_cnt_d;
  logic [2:0]   layer_q, layer_d;
  logic [7:0]   idx_q, idx_d;
  logic         s1_vld_q, s1_vld_d, s1_wsum_q, s1_wsum_d;
  logic [11:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_zeta_q, s1_zeta_d;
  logic [7:0]   s1_ja_q, s1_ja_d, s1_jb_q, s1_jb_d;
  logic         s2_vld_q, s2_vld_d, s2_wsum_q, s2_wsum_d;
  logic [11:0]  s2_sum_q, s2_sum_d;
  logic [23:0]  s2_prod_q, s2_prod_d;
  logic [7:0]   s2_ja_q, s2_ja_d, s2_jb_q, s2_jb_d;
  logic [127:0] data_out_q, data_out_d;
  logic         valid_out_q, valid_out_d, done_q, done_d;
  logic         load_we;

  logic [11:0]  coef_ram [256];
  logic [11:0]  zeta_rom [128];
  logic [11:0]  lane_val [8];
  logic [127:0] out_word;

  logic [7:0]   bf_idx, bf_len, bf_mask, bf_grp, addr_a, addr_b;
  logic [6:0]   zeta_k;
  logic [12:0]  sum_raw;
  logic [11:0]  sum_mod, diff_mod, prod_mod;
  logic [23:0]  prod;
  logic         pipe_busy;

  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_zeta
      localparam logic [11:0] ZV = zeta_of(gi);
      assign zeta_rom[gi] = ZV;
    end
    for (gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi);
      logic [11:0] raw;
      logic [3:0]  hi_unused;
      assign raw        = data_in[16*gi +: 12];
      assign hi_unused  = data_in[16*gi+12 +: 4];
      assign lane_val[gi] = (raw >= 12'd3329) ? raw - 12'd3329 : raw;
      assign out_word[16*gi +: 16] = {4'b0000, coef_ram[{word_cnt_q, LANE}]};
    end
  endgenerate

  assign ready_in  = (state_q == ST_LOAD);
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign done      = done_q;
  assign pipe_busy = s1_vld_q | s2_vld_q;

  // Butterfly addressing: j = 2*len*group + offset, partner j+len, zeta index
  // counts down from 127 across all groups of all layers.
  always_comb begin
    bf_idx  = {1'b0, idx_q[6:0]};
    bf_len  = 8'd2 << layer_q;
    bf_mask = bf_len - 8'd1;
    bf_grp  = bf_idx >> (layer_q + 3'd1);
    addr_a  = bf_idx + (bf_idx & ~bf_mask);
    addr_b  = addr_a + bf_len;
    zeta_k  = 7'((8'd128 >> layer_q) - 8'd1 - bf_grp);
  end

  // Butterfly arithmetic: stage 1 forms (a+b) and zeta*(b-a); stage 2 reduces.
  always_comb begin
    sum_raw  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sum_mod  = (sum_raw >= 13'd3329) ? 12'(sum_raw - 13'd3329) : sum_raw[11:0];
    diff_mod = (s1_b_q >= s1_a_q) ? (s1_b_q - s1_a_q)
                                  : 12'({1'b0, s1_b_q} + 13'd3329 - {1'b0, s1_a_q});
    prod     = 24'(s1_zeta_q) * 24'(diff_mod);
    prod_mod = mod_q(s2_prod_q);
  end

  // Sequencer: issues loads, butterflies, scale ops and output words. The
  // first issue of each layer/phase waits for the pipeline to drain so every
  // read sees the previous layer's writes.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    layer_d     = layer_q;
    idx_d       = idx_q;
    s1_vld_d    = 1'b0;
    s1_wsum_d   = 1'b0;
    s1_a_d      = '0;
    s1_b_d      = '0;
    s1_zeta_d   = '0;
    s1_ja_d     = '0;
    s1_jb_d     = '0;
    s2_vld_d    = s1_vld_q;
    s2_wsum_d   = s1_wsum_q;
    s2_sum_d    = sum_mod;
    s2_prod_d   = prod;
    s2_ja_d     = s1_ja_q;
    s2_jb_d     = s1_jb_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    done_d      = 1'b0;
    load_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          layer_d    = '0;
          idx_d      = '0;
        end
      end
      ST_LOAD: begin
        if (valid_in) begin
          load_we    = 1'b1;
          word_cnt_d = word_cnt_q + 5'd1;
          if (word_cnt_q == 5'd31) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (!(idx_q == 8'd0 && pipe_busy)) begin
          s1_vld_d  = 1'b1;
          s1_wsum_d = 1'b1;
          s1_a_d    = coef_ram[addr_a];
          s1_b_d    = coef_ram[addr_b];
          s1_zeta_d = zeta_rom[zeta_k];
          s1_ja_d   = addr_a;
          s1_jb_d   = addr_b;
          if (idx_q[6:0] == 7'd127) begin
            idx_d = '0;
            if (layer_q == 3'd6) begin
              layer_d = '0;
              state_d = ST_SCALE;
            end else begin
              layer_d = layer_q + 3'd1;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_SCALE: begin
        // Scale reuses the butterfly pipe with a = 0: zeta*(b-0), sum unused.
        if (!(idx_q == 8'd0 && pipe_busy)) begin
          s1_vld_d  = 1'b1;
          s1_b_d    = coef_ram[idx_q];
          s1_zeta_d = SCALE_F;
          s1_ja_d   = idx_q;
          s1_jb_d   = idx_q;
          idx_d     = idx_q + 8'd1;
          if (idx_q == 8'd255) state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (!(word_cnt_q == 5'd0 && pipe_busy)) begin
          valid_out_d = 1'b1;
          data_out_d  = out_word;
          word_cnt_d  = word_cnt_q + 5'd1;
          if (word_cnt_q == 5'd31) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coefficient RAM writes: whole words during load, butterfly results after.
  always_ff @(posedge clk) begin
    if (load_we) begin
      for (int i = 0; i < 8; i++) coef_ram[{word_cnt_q, 3'(i)}] <= lane_val[i];
    end
    if (s2_vld_q) begin
      if (s2_wsum_q) coef_ram[s2_ja_q] <= s2_sum_q;
      coef_ram[s2_jb_q] <= prod_mod;
    end
  end

  // Control, pipeline and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      layer_q     <= '0;
      idx_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_wsum_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_zeta_q   <= '0;
      s1_ja_q     <= '0;
      s1_jb_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_wsum_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_prod_q   <= '0;
      s2_ja_q     <= '0;
      s2_jb_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      layer_q     <= layer_d;
      idx_q       <= idx_d;
      s1_vld_q    <= s1_vld_d;
      s1_wsum_q   <= s1_wsum_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_zeta_q   <= s1_zeta_d;
      s1_ja_q     <= s1_ja_d;
      s1_jb_q     <= s1_jb_d;
      s2_vld_q    <= s2_vld_d;
      s2_wsum_q   <= s2_wsum_d;
      s2_sum_q    <= s2_sum_d;
      s2_prod_q   <= s2_prod_d;
      s2_ja_q     <= s2_ja_d;
      s2_jb_q     <= s2_jb_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_kyber_intt_core.sv
// Testbench for kyber_intt_core: directed and random transforms checked
// against a plain-arithmetic Kyber NTT / inverse NTT model.
module tb_kyber_intt_core;
  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         reset, start, valid_in;
  logic [127:0] data_in;
  logic         ready_in, valid_out, done;
  logic [127:0] data_out;

  always #5 clk = ~clk;

  kyber_intt_core dut (
    .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
    .data_in(data_in), .ready_in(ready_in), .data_out(data_out),
    .valid_out(valid_out), .done(done)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int zetas[128];
  int poly[256];
  logic [127:0] in_words[32];
  logic [127:0] exp_words[32];
  logic [127:0] out_words[32];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int fq(input int x);
    return ((x % Q) + Q) % Q;
  endfunction

  task automatic build_zetas();
    for (int k = 0; k < 128; k++) begin
      int e;
      int z;
      e = 0;
      for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) e |= 1 << (6 - b);
      z = 1;
      for (int i = 0; i < e; i++) z = (z * 17) % Q;
      zetas[k] = z;
    end
  endtask

  // Reference: reduce inputs, Kyber invntt in plain domain, scale by 128^-1.
  task automatic model_inv();
    int r[256];
    int k;
    for (int i = 0; i < 256; i++) begin
      int v;
      v = int'(in_words[i/8][16*(i%8) +: 12]);
      if (v >= Q) v -= Q;
      r[i] = v;
    end
    k = 127;
    for (int len = 2; len <= 128; len *= 2) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        int zeta;
        zeta = zetas[k];
        k--;
        for (int j = s; j < s + len; j++) begin
          int a;
          int b;
          a = r[j];
          b = r[j+len];
          r[j] = fq(a + b);
          r[j+len] = fq(zeta * (b - a));
        end
      end
    end
    for (int i = 0; i < 256; i++) exp_words[i/8][16*(i%8) +: 16] = 16'(fq(r[i] * 3303));
  endtask

  // Forward Kyber NTT of poly[] into in_words[]; expected output is poly itself.
  task automatic forward_from_poly();
    int r[256];
    int k;
    for (int i = 0; i < 256; i++) r[i] = poly[i];
    k = 1;
    for (int len = 128; len >= 2; len /= 2) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        int zeta;
        zeta = zetas[k];
        k++;
        for (int j = s; j < s + len; j++) begin
          int t;
          t = fq(zeta * r[j+len]);
          r[j+len] = fq(r[j] - t);
          r[j] = fq(r[j] + t);
        end
      end
    end
    for (int i = 0; i < 256; i++) begin
      in_words[i/8][16*(i%8) +: 16] = 16'(r[i]);
      exp_words[i/8][16*(i%8) +: 16] = 16'(poly[i]);
    end
  endtask

  task automatic set_const_pattern(input logic [15:0] v);
    for (int w = 0; w < 32; w++) begin
      in_words[w] = {8{16'h0000}};
      for (int j = 0; j < 8; j += 2) in_words[w][16*j +: 16] = v;
      exp_words[w] = '0;
    end
    exp_words[0] = {112'b0, v};
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input bit gaps);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    while (acc < 32 && guard < 2000) begin
      if (ready_in === 1'b1 && (!gaps || $urandom_range(0, 3) != 0)) begin
        valid_in = 1'b1;
        data_in = in_words[acc];
        acc++;
      end else begin
        valid_in = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      guard++;
    end
    valid_in = 1'b0;
    check("words accepted", 128'(acc), 128'd32);
    check("ready_in low after 32nd", {127'b0, ready_in}, '0);
    repeat (3) begin
      valid_in = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic collect(input bit poke);
    int cyc;
    int vcnt;
    logic [127:0] nib;
    cyc = 3;
    vcnt = 0;
    while (valid_out !== 1'b1 && cyc < 2500) begin
      start = (poke && cyc == 100);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency within 2000", {127'b0, cyc <= 2000}, 128'd1);
    nib = '0;
    for (int i = 0; i < 32; i++) begin
      out_words[i] = data_out;
      if (valid_out === 1'b1) vcnt++;
      nib |= data_out & {8{16'hF000}};
      @(negedge clk);
    end
    check("valid_out run length", 128'(vcnt), 128'd32);
    check("upper nibbles zero", nib, '0);
    check("done after last word", {126'b0, valid_out, done}, 128'b01);
    @(negedge clk);
    check("done single cycle", {125'b0, valid_out, done, ready_in}, '0);
  endtask

  task automatic run_case(input string name, input bit gaps, input bit poke);
    do_start();
    load_words(gaps);
    collect(poke);
    for (int w = 0; w < 32; w++) check($sformatf("%s w%0d", name, w), out_words[w], exp_words[w]);
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    start = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    build_zetas();
    repeat (3) @(negedge clk);
    check("reset ready_in", {127'b0, ready_in}, '0);
    check("reset valid_out", {127'b0, valid_out}, '0);
    check("reset done", {127'b0, done}, '0);
    check("reset data_out", data_out, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 32; w++) begin
      in_words[w] = '0;
      exp_words[w] = '0;
    end
    run_case("zeros", 1'b0, 1'b0);

    set_const_pattern(16'd1);
    run_case("ones", 1'b0, 1'b0);

    set_const_pattern(16'd5);
    run_case("fives", 1'b1, 1'b0);

    set_const_pattern(16'd3328);
    run_case("q-1", 1'b1, 1'b0);

    for (int w = 0; w < 32; w++)
      for (int j = 0; j < 8; j++) in_words[w][16*j +: 16] = 16'($urandom_range(0, Q - 1));
    model_inv();
    run_case("random", 1'b1, 1'b1);

    for (int w = 0; w < 32; w++)
      for (int j = 0; j < 8; j++) in_words[w][16*j +: 16] = 16'($urandom_range(0, 65535));
    model_inv();
    run_case("noncanon", 1'b1, 1'b0);

    for (int i = 0; i < 256; i++) poly[i] = $urandom_range(0, Q - 1);
    forward_from_poly();
    run_case("roundtrip", 1'b1, 1'b0);

    set_const_pattern(16'd1);
    do_start();
    load_words(1'b1);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (valid_out !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset flags", {125'b0, ready_in, valid_out, done}, '0);
    check("midreset data_out", data_out, '0);
    reset = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      if (valid_out !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check("aborted run silent", {127'b0, bad}, '0);
    run_case("after reset", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/kyber_intt_core.md
Name: kyber_intt_core

Overview:
- Kyber inverse number-theoretic transform over Z_q, q = 3329, on one 256-coefficient polynomial.
- Streams in 32 words of 128 bits (NTT domain), computes the full inverse transform in place, and streams out 32 words (normal domain).
- Sits after the pointwise-multiply stage in the NTT datapath.

Parameters:
- None. q = 3329, n = 256, 7 layers, scale factor 3303 (= 128^-1 mod q) and zeta table are fixed constants.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a transform when idle.
- valid_in  in  1  data_in valid; word accepted when valid_in & ready_in.
- data_in  in  128  8 coefficient lanes; lane j = bits [16j+15:16j] = coefficient 8*w+j of input word w.
- ready_in  out  1  high while the block can accept input words.
- data_out  out  128  same lane packing; upper 4 bits of every lane are 0.
- valid_out  out  1  data_out holds output word; no backpressure.
- done  out  1  one-cycle pulse after the final output word.

Behaviour:
- Reset: ready_in=0, valid_out=0, done=0, data_out=0, word counters=0, state=IDLE. Reset mid-operation aborts and returns to IDLE; coefficient RAM contents don't care.
- States: IDLE -> LOAD (on start) -> COMPUTE -> SCALE -> OUTPUT -> DONE -> IDLE.
- start is ignored outside IDLE.
- LOAD:
  - ready_in=1 continuously until 32 words have been accepted, in order w = 0..31.
  - ready_in falls the cycle after the 32nd acceptance.
  - Gaps in valid_in are allowed; valid_in while ready_in=0 is ignored.
- Input coefficient handling: low 12 bits of each lane are used; values ≥ 3329 are reduced by one conditional subtraction; bits [15:12] are ignored.
- COMPUTE: Gentleman-Sande butterflies, matching the Kyber reference invntt in the plain (non-Montgomery) domain.
  - k starts at 127.
  - For len = 2, 4, ..., 128; for each block start s = 0, 2len, 4len, ... < 256: zeta = 17^brv7(k) mod q, then k = k-1.
  - For j in [s, s+len): a = r[j], b = r[j+len]; r[j] = (a+b) mod q; r[j+len] = zeta*(b-a) mod q.
  - Each layer completes before the next reads its results.
  - All intermediates are canonical in [0, q).
- SCALE: r[i] = 3303*r[i] mod q for all i.
- Result is the exact inverse of the plain Kyber forward NTT.
- Modular multiply: 12x12 product, reduced to [0, q) (Barrett or equivalent); results must be bit-exact.
- OUTPUT:
  - 32 consecutive cycles with valid_out=1, words 0..31 in order, lane packing as input.
  - data_out holds each word for its valid_out cycle.
  - valid_out=0 otherwise.
- DONE: done=1 for exactly one cycle, the cycle after the last valid_out; valid_out=0 in that cycle. Then return to IDLE, ready for a new start.
- Latency: first valid_out no more than 2000 cycles after the 32nd input acceptance. A reference implementation runs one butterfly per cycle (896 cycles) plus 256 scale cycles.
- Back-to-back transforms: a new start accepted in IDLE after done fully restarts the block; no state leaks from the previous run.

Test Plan:
- All-zero input (32 words of 0) -> 32 output words of 0, then a single done pulse one cycle after the last valid_out.
- Every word = 128'h0000_0001_0000_0001_0000_0001_0000_0001 (hat of polynomial 1) -> output word 0 = 128'h1, words 1..31 = 0.
- Same pattern with 5 in place of 1 -> output word 0 = 128'h5, others 0. Also 3328 (q-1) in place of 1 -> output word 0 = 128'hD00.
- Random canonical inputs vs software model (Kyber plain NTT^-1). Round trip: forward-NTT a random polynomial in software, feed it, and the output must equal the original. Check that all lane upper nibbles are 0.
- Handshake: valid_in issued one cycle after ready_in observed, with random gaps -> exactly 32 words accepted, ready_in drops after the 32nd. A start pulse during COMPUTE has no effect.
- Assert reset mid-COMPUTE, then rerun the second test's stimulus -> correct output; no valid_out/done from the aborted run.
